// File: rtl/spi_bus_bridge.sv
// spi_bus_bridge
//   Command sequencer between the spi_slave byte shifter and the 8-bit system
//   memory bus. Runs in the system clock domain and synchronizes the SCLK-domain
//   byte-done strobe. Decodes a 3/4-byte host protocol into single bus reads or
//   writes on the 16-bit address space and returns read data through spi_tx.
//
//   Host protocol:
//     WRITE : 8'b10xx_xxxx, addr_hi, addr_lo, data
//     READ  : 8'b11xx_xxxx, addr_hi, addr_lo, <byte that shifts out read data>
//     other : remaining bytes are ignored until the next CS edge
//
//   Optional feature macro: SPI_BRIDGE_BURST_EN
//     defined   -> address auto-increments after every ack; writes continue
//                  with further data bytes, reads re-issue at the next address
//     undefined -> one transaction per command, then back to command decode
//
//   Ports:
//     clk, reset        system clock (>= 8x SCLK), synchronous active-high reset
//     spi_cs_n          raw chip select (asynchronous)
//     spi_done, spi_rx  spi_slave byte-complete flag and received byte
//     spi_tx            byte the spi_slave shifts out during the next SPI byte
//     bus_addr, bus_wr_data, bus_we, bus_req   bus request side
//     bus_rd_data, bus_ack                     bus completion side
//     busy              high while a bus request is outstanding
//     overrun           sticky: a byte arrived while waiting on the bus

module spi_bus_bridge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_cs_n,
  input  logic        spi_done,
  input  logic [7:0]  spi_rx,
  output logic [7:0]  spi_tx,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wr_data,
  input  logic [7:0]  bus_rd_data,
  output logic        bus_we,
  output logic        bus_req,
  input  logic        bus_ack,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [2:0] {
    ST_CMD      = 3'd0,
    ST_ADDR_HI  = 3'd1,
    ST_ADDR_LO  = 3'd2,
    ST_DATA     = 3'd3,
    ST_BUS_WAIT = 3'd4,
    ST_DISCARD  = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES:0]   done_sync_q, done_sync_d;
  logic                   cs_prev_q, done_prev_q;
  logic [7:0]             rx_q, rx_d;
  logic                   is_read_q, is_read_d;
  logic                   cs_evt_q, cs_evt_d;
  logic [15:0]            bus_addr_q, bus_addr_d;
  logic [7:0]             bus_wr_data_q, bus_wr_data_d;
  logic                   bus_we_q, bus_we_d;
  logic                   bus_req_q, bus_req_d;
  logic [7:0]             spi_tx_q, spi_tx_d;
  logic                   overrun_q, overrun_d;

  logic cs_s, done_s, bstb, cs_fall, cs_rise;

  // done gets one more stage than CS so a CS deassertion always wins over the
  // spurious done rise it provokes in the shifter.
  assign cs_s    = cs_sync_q[SYNC_STAGES-1];
  assign done_s  = done_sync_q[SYNC_STAGES];
  assign bstb    = done_s & ~done_prev_q & ~cs_s;
  assign cs_fall = ~cs_s & cs_prev_q;
  assign cs_rise = cs_s & ~cs_prev_q;

  assign spi_tx      = spi_tx_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wr_data = bus_wr_data_q;
  assign bus_we      = bus_we_q;
  assign bus_req     = bus_req_q;
  assign busy        = bus_req_q;
  assign overrun     = overrun_q;

  // Synchronizer shift chains.
  always_comb begin
    cs_sync_d[0]   = spi_cs_n;
    done_sync_d[0] = spi_done;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      cs_sync_d[i] = cs_sync_q[i-1];
    end
    for (int i = 1; i <= SYNC_STAGES; i++) begin
      done_sync_d[i] = done_sync_q[i-1];
    end
  end

  // Command decode, bus handshake and CS edge handling.
  always_comb begin
    state_d       = state_q;
    rx_d          = rx_q;
    is_read_d     = is_read_q;
    cs_evt_d      = cs_evt_q;
    bus_addr_d    = bus_addr_q;
    bus_wr_data_d = bus_wr_data_q;
    bus_we_d      = bus_we_q;
    bus_req_d     = bus_req_q;
    spi_tx_d      = spi_tx_q;
    overrun_d     = overrun_q;

    // rx_d carries the byte in its strobe cycle so decode needs no extra cycle.
    if (bstb) begin
      rx_d = spi_rx;
    end else begin
      rx_d = rx_q;
    end

    case (state_q)
      ST_CMD: begin
        if (bstb) begin
          if (rx_d[7:6] == 2'b10) begin
            is_read_d = 1'b0;
            state_d   = ST_ADDR_HI;
          end else if (rx_d[7:6] == 2'b11) begin
            is_read_d = 1'b1;
            state_d   = ST_ADDR_HI;
          end else begin
            state_d   = ST_DISCARD;
          end
        end
      end
      ST_ADDR_HI: begin
        if (bstb) begin
          bus_addr_d[15:8] = rx_d;
          state_d          = ST_ADDR_LO;
        end
      end
      ST_ADDR_LO: begin
        if (bstb) begin
          bus_addr_d[7:0] = rx_d;
          if (is_read_q) begin
            bus_req_d = 1'b1;
            bus_we_d  = 1'b0;
            cs_evt_d  = 1'b0;
            state_d   = ST_BUS_WAIT;
          end else begin
            state_d   = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (bstb) begin
          bus_wr_data_d = rx_d;
          bus_req_d     = 1'b1;
          bus_we_d      = 1'b1;
          cs_evt_d      = 1'b0;
          state_d       = ST_BUS_WAIT;
        end
      end
      ST_BUS_WAIT: begin
        // Bytes cannot be accepted while the bus is busy; they are dropped.
        if (bstb) begin
          overrun_d = 1'b1;
        end
        // Remember any CS edge so the request can finish before we leave.
        if (cs_fall | cs_rise) begin
          cs_evt_d = 1'b1;
        end
        if (bus_ack && bus_req_q) begin
          bus_req_d = 1'b0;
          if (is_read_q) begin
            spi_tx_d = bus_rd_data;
          end
          if (cs_s | cs_evt_q | cs_fall | cs_rise) begin
            state_d = ST_CMD;
          end else begin
`ifdef SPI_BRIDGE_BURST_EN
            bus_addr_d = bus_addr_q + 16'd1;
            if (is_read_q) begin
              bus_req_d = 1'b1;
              state_d   = ST_BUS_WAIT;
            end else begin
              state_d   = ST_DATA;
            end
`else
            state_d = ST_CMD;
`endif
          end
        end
      end
      ST_DISCARD: begin
        state_d = ST_DISCARD;
      end
      default: begin
        state_d = ST_CMD;
      end
    endcase

    if (cs_fall) begin
      overrun_d = 1'b0;
    end
    // An outstanding request is never withdrawn; BUS_WAIT exits on its ack.
    if ((cs_fall | cs_rise) && (state_q != ST_BUS_WAIT)) begin
      state_d = ST_CMD;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_CMD;
      cs_sync_q     <= {SYNC_STAGES{1'b1}};
      done_sync_q   <= {(SYNC_STAGES+1){1'b0}};
      cs_prev_q     <= 1'b1;
      done_prev_q   <= 1'b0;
      rx_q          <= 8'h00;
      is_read_q     <= 1'b0;
      cs_evt_q      <= 1'b0;
      bus_addr_q    <= 16'h0000;
      bus_wr_data_q <= 8'h00;
      bus_we_q      <= 1'b0;
      bus_req_q     <= 1'b0;
      spi_tx_q      <= 8'h00;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cs_sync_q     <= cs_sync_d;
      done_sync_q   <= done_sync_d;
      cs_prev_q     <= cs_s;
      done_prev_q   <= done_s;
      rx_q          <= rx_d;
      is_read_q     <= is_read_d;
      cs_evt_q      <= cs_evt_d;
      bus_addr_q    <= bus_addr_d;
      bus_wr_data_q <= bus_wr_data_d;
      bus_we_q      <= bus_we_d;
      bus_req_q     <= bus_req_d;
      spi_tx_q      <= spi_tx_d;
      overrun_q     <= overrun_d;
    end
  end

endmodule

// File: tb/tb_spi_bus_bridge.sv
module tb_spi_bus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_cs_n;
  logic        spi_done;
  logic [7:0]  spi_rx;
  logic [7:0]  spi_tx;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wr_data;
  logic [7:0]  bus_rd_data;
  logic        bus_we;
  logic        bus_req;
  logic        bus_ack;
  logic        busy;
  logic        overrun;

  always #5 clk = ~clk;

  spi_bus_bridge #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .spi_cs_n(spi_cs_n), .spi_done(spi_done),
    .spi_rx(spi_rx), .spi_tx(spi_tx), .bus_addr(bus_addr),
    .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data), .bus_we(bus_we),
    .bus_req(bus_req), .bus_ack(bus_ack), .busy(busy), .overrun(overrun)
  );

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wd;
  } txn_t;

  txn_t       exp_q[$];
  int         vec_cnt = 0;
  int         err_cnt = 0;
  int         ack_delay = 3;
  logic [7:0] rd_value = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic we, input logic [15:0] addr, input logic [7:0] wd);
    txn_t t;
    t.we = we; t.addr = addr; t.wd = wd;
    exp_q.push_back(t);
  endtask

  // Abstract spi_slave: present a byte and hold done high long enough to sync.
  task automatic send_byte(input logic [7:0] b);
    spi_rx   = b;
    spi_done = 1'b1;
    tick(6);
    spi_done = 1'b0;
    tick(6);
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    tick(4);
  endtask

  task automatic cs_high();
    spi_cs_n = 1'b1;
    tick(4);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy && n < limit) begin
      tick(1);
      n++;
    end
    check("idle_timeout", busy, 1'b0);
  endtask

  task automatic wait_busy(input int limit);
    int n = 0;
    while (!busy && n < limit) begin
      tick(1);
      n++;
    end
    check("busy_timeout", busy, 1'b1);
  endtask

  // Bus arbiter model plus scoreboard monitor on each new request.
  initial begin : monitor
    logic req_prev;
    int   cnt;
    txn_t e;
    req_prev = 1'b0;
    cnt      = 0;
    bus_ack  = 1'b0;
    bus_rd_data = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        req_prev = 1'b0;
        cnt      = 0;
        bus_ack  = 1'b0;
      end else begin
        if (bus_req && !req_prev) begin
          if (exp_q.size() == 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL unexpected_req: got addr %0h we %0b expected no request", bus_addr, bus_we);
          end else begin
            e = exp_q.pop_front();
            check("req_we", bus_we, e.we);
            check("req_addr", bus_addr, e.addr);
            if (e.we) begin
              check("req_wdata", bus_wr_data, e.wd);
            end
          end
        end
        if (bus_ack) begin
          bus_ack = 1'b0;
          cnt     = 0;
`ifndef SPI_BRIDGE_BURST_EN
          check("req_drop", bus_req, 1'b0);
`endif
        end else if (bus_req) begin
          cnt++;
          if (cnt >= ack_delay) begin
            bus_ack     = 1'b1;
            bus_rd_data = rd_value;
          end
        end else begin
          cnt = 0;
        end
        req_prev = bus_req;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    reset    = 1'b1;
    spi_cs_n = 1'b1;
    spi_done = 1'b0;
    spi_rx   = 8'h00;
    tick(4);
    reset = 1'b0;
    tick(1);
    check("rst_spi_tx", spi_tx, 8'h00);
    check("rst_bus_addr", bus_addr, 16'h0000);
    check("rst_bus_wr_data", bus_wr_data, 8'h00);
    check("rst_bus_we", bus_we, 1'b0);
    check("rst_bus_req", bus_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);

    // Single write.
    cs_low();
    push(1'b1, 16'h1234, 8'hA5);
    send_byte(8'h80); send_byte(8'h12); send_byte(8'h34); send_byte(8'hA5);
    wait_idle(50);
    check("write_no_overrun", overrun, 1'b0);
    cs_high();

    // Single read; the following byte shifts the read data out.
    rd_value = 8'h5A;
    cs_low();
    push(1'b0, 16'h8000, 8'h00);
    send_byte(8'hC0); send_byte(8'h80); send_byte(8'h00);
    wait_idle(50);
    tick(2);
    check("read_tx", spi_tx, 8'h5A);
    send_byte(8'h00);
    cs_high();
    wait_idle(50);
    check("tx_hold_cs", spi_tx, 8'h5A);

    // Overrun: a fifth byte while the write is still waiting on the bus.
    ack_delay = 200;
    cs_low();
    push(1'b1, 16'h0010, 8'h3C);
    send_byte(8'h80); send_byte(8'h00); send_byte(8'h10); send_byte(8'h3C);
    send_byte(8'h99);
    check("overrun_set", overrun, 1'b1);
    check("busy_during_wait", busy, 1'b1);
    wait_idle(300);
    check("overrun_sticky", overrun, 1'b1);
    ack_delay = 3;
    cs_high();
    check("overrun_after_cs_rise", overrun, 1'b1);
    cs_low();
    check("overrun_clear", overrun, 1'b0);
    cs_high();

    // CS abort mid-command, then a fresh write.
    cs_low();
    send_byte(8'h80); send_byte(8'h12);
    cs_high();
    tick(20);
    check("abort_no_req", busy, 1'b0);
    cs_low();
    push(1'b1, 16'h0001, 8'h77);
    send_byte(8'h80); send_byte(8'h00); send_byte(8'h01); send_byte(8'h77);
    wait_idle(50);
    cs_high();

    // Invalid command discards the rest of the frame.
    cs_low();
    send_byte(8'h3F); send_byte(8'h80); send_byte(8'h00); send_byte(8'h00); send_byte(8'h11);
    tick(10);
    check("discard_no_req", busy, 1'b0);
    cs_high();

    // Reset while a request is outstanding.
    ack_delay = 1000;
    cs_low();
    push(1'b1, 16'hABCD, 8'hEF);
    send_byte(8'h80); send_byte(8'hAB); send_byte(8'hCD); send_byte(8'hEF);
    wait_busy(50);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("rst_wait_bus_req", bus_req, 1'b0);
    check("rst_wait_busy", busy, 1'b0);
    check("rst_wait_addr", bus_addr, 16'h0000);
    check("rst_wait_wdata", bus_wr_data, 8'h00);
    ack_delay = 3;
    tick(4);
    push(1'b1, 16'h0002, 8'h55);
    send_byte(8'h80); send_byte(8'h00); send_byte(8'h02); send_byte(8'h55);
    wait_idle(50);
    cs_high();

`ifdef SPI_BRIDGE_BURST_EN
    // Burst write wrapping the address space.
    cs_low();
    push(1'b1, 16'hFFFF, 8'h01);
    push(1'b1, 16'h0000, 8'h02);
    send_byte(8'h80); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h01); send_byte(8'h02);
    wait_idle(50);
    cs_high();
`endif

    tick(20);
    check("pending_expected", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
